next_pc_unit: RTL and testbench

//  Next-PC generator sitting directly upstream of the PC register: computes the
//  6-bit address the PC loads on every rising clock edge. Handles sequential,

---
 rtl/next_pc_unit_pkg.sv | 22 ++
 rtl/npc_ras.sv | 56 +++++
 rtl/next_pc_unit.sv | 128 ++++++++++++
 tb/tb_next_pc_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/next_pc_unit_pkg.sv
// Shared definitions for the next-PC unit: default widths, vectors and
// flow-select encodings used by the top-level priority mux.
package next_pc_unit_pkg;

  localparam int          NPC_AW           = 6;
  localparam int          NPC_RAS_DEPTH    = 4;
  localparam logic [5:0]  NPC_RESET_VECTOR = 6'h00;
  localparam logic [5:0]  NPC_TRAP_VECTOR  = 6'h3F;

  // Which source drives next_pc this cycle.
  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_CALL = 3'd3,
    SEL_RET  = 3'd4,
    SEL_HOLD = 3'd5,
    SEL_TRAP = 3'd6,
    SEL_RST  = 3'd7
  } npc_sel_e;

endpackage

// File: rtl/npc_ras.sv
// Circular return-address stack. The pointer addresses the next free slot;
// a push when full overwrites the oldest entry and keeps the count saturated.
module npc_ras #(
  parameter int AW    = 6,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] mem_q, mem_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign top   = mem_q[ptr_q - PW'(1)];

  // Next-state for entries, pointer and count; push takes precedence over pop.
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_q + PW'(1);
      if (!full) cnt_d = cnt_q + CW'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  // State registers; reset discards every entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC generator: priority mux over hold/return/call/jump/branch/sequential
// flow, with a return-address stack for call/return.
// Optional feature macro: NPC_RAS_TRAP_EN -- RAS overflow/underflow redirects
// to TRAP_VECTOR and sets a sticky ras_fault instead of wrapping/ignoring.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter int          AW           = NPC_AW,
  parameter int          RAS_DEPTH    = NPC_RAS_DEPTH,
  parameter logic [AW-1:0] RESET_VECTOR = AW'(NPC_RESET_VECTOR),
  parameter logic [AW-1:0] TRAP_VECTOR  = AW'(NPC_TRAP_VECTOR)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [AW-1:0] pc,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_offset,
  input  logic          jump,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] jump_target,
  output logic [AW-1:0] next_pc,
  output logic          ras_empty,
  output logic          ras_full,
  output logic          ras_fault
);

  npc_sel_e      sel;
  logic          ras_push, ras_pop;
  logic [AW-1:0] ras_top;
  logic [AW-1:0] pc_inc, br_tgt;

  // Both adders wrap naturally at AW bits.
  assign pc_inc = pc + AW'(1);
  assign br_tgt = pc_inc + branch_offset;

  npc_ras #(.AW(AW), .DEPTH(RAS_DEPTH)) u_ras (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

`ifdef NPC_RAS_TRAP_EN
  logic trap;
`endif

  // Flow selection in priority order; RAS push/pop only on an unstalled cycle.
  always_comb begin
    sel      = SEL_SEQ;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
`ifdef NPC_RAS_TRAP_EN
    trap     = 1'b0;
`endif
    if (!reset_n) begin
      sel = SEL_RST;
    end else if (stall) begin
      sel = SEL_HOLD;
    end else if (ret) begin
      // call is ignored when ret is present: pop only.
      if (!ras_empty) begin
        sel     = SEL_RET;
        ras_pop = 1'b1;
      end
`ifdef NPC_RAS_TRAP_EN
      else begin
        sel  = SEL_TRAP;
        trap = 1'b1;
      end
`endif
    end else if (call) begin
      sel      = SEL_CALL;
      ras_push = 1'b1;
`ifdef NPC_RAS_TRAP_EN
      if (ras_full) begin
        sel      = SEL_TRAP;
        ras_push = 1'b0;
        trap     = 1'b1;
      end
`endif
    end else if (jump) begin
      sel = SEL_JMP;
    end else if (branch_taken) begin
      sel = SEL_BR;
    end
  end

  // Output mux for the selected flow.
  always_comb begin
    next_pc = pc_inc;
    case (sel)
      SEL_RST:  next_pc = RESET_VECTOR;
      SEL_HOLD: next_pc = pc;
      SEL_RET:  next_pc = ras_top;
      SEL_CALL: next_pc = jump_target;
      SEL_JMP:  next_pc = jump_target;
      SEL_BR:   next_pc = br_tgt;
      SEL_TRAP: next_pc = TRAP_VECTOR;
      default:  next_pc = pc_inc;
    endcase
  end

`ifdef NPC_RAS_TRAP_EN
  logic fault_q, fault_d;

  // Sticky fault: set by any trapped over/underflow, cleared only by reset.
  always_comb begin
    fault_d = fault_q | trap;
  end

  // Fault flag register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fault_q <= 1'b0;
    else          fault_q <= fault_d;
  end

  assign ras_fault = fault_q;
`else
  assign ras_fault = 1'b0;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit. Expected values are
// hand-computed; trap-mode expectations follow NPC_RAS_TRAP_EN.
module tb_next_pc_unit;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [5:0] pc;
  logic       stall, branch_taken, jump, call, ret;
  logic [5:0] branch_offset, jump_target;
  logic [5:0] next_pc;
  logic       ras_empty, ras_full, ras_fault;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  next_pc_unit dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pc            (pc),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .call          (call),
    .ret           (ret),
    .jump_target   (jump_target),
    .next_pc       (next_pc),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_fault     (ras_fault)
  );

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
    branch_offset = 6'h00; jump_target = 6'h00;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    pc = 6'h12;
    #2;
    checks++; if (next_pc !== 6'h00) begin errors++; $display("FAIL reset_next_pc got=%h exp=00", next_pc); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", ras_empty); end
    checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", ras_full); end
    checks++; if (ras_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", ras_fault); end
    @(negedge clock);
    reset_n = 1;
    #1;
    checks++; if (next_pc !== 6'h13) begin errors++; $display("FAIL release_seq got=%h exp=13", next_pc); end
    tick();
  endtask

  task automatic test_seq_branch();
    idle();
    pc = 6'h3F; #1;
    checks++; if (next_pc !== 6'h00) begin errors++; $display("FAIL seq_wrap got=%h exp=00", next_pc); end
    pc = 6'h02; branch_taken = 1; branch_offset = 6'h3C; #1;
    checks++; if (next_pc !== 6'h3F) begin errors++; $display("FAIL branch_back_wrap got=%h exp=3F", next_pc); end
    pc = 6'h10; branch_offset = 6'h05; #1;
    checks++; if (next_pc !== 6'h16) begin errors++; $display("FAIL branch_fwd got=%h exp=16", next_pc); end
    pc = 6'h3E; branch_offset = 6'h02; #1;
    checks++; if (next_pc !== 6'h01) begin errors++; $display("FAIL branch_fwd_wrap got=%h exp=01", next_pc); end
    jump = 1; jump_target = 6'h2A; #1;
    checks++; if (next_pc !== 6'h2A) begin errors++; $display("FAIL jump_over_branch got=%h exp=2A", next_pc); end
    tick();
    idle();
  endtask

  task automatic test_call_ret();
    idle();
    pc = 6'h05; call = 1; jump_target = 6'h20; #1;
    checks++; if (next_pc !== 6'h20) begin errors++; $display("FAIL call1 got=%h exp=20", next_pc); end
    tick();
    pc = 6'h21; jump_target = 6'h30; #1;
    checks++; if (next_pc !== 6'h30) begin errors++; $display("FAIL call2 got=%h exp=30", next_pc); end
    tick();
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL after_calls_empty got=%b exp=0", ras_empty); end
    idle();
    pc = 6'h30; ret = 1; #1;
    checks++; if (next_pc !== 6'h22) begin errors++; $display("FAIL ret1 got=%h exp=22", next_pc); end
    tick();
    pc = 6'h22; #1;
    checks++; if (next_pc !== 6'h06) begin errors++; $display("FAIL ret2 got=%h exp=06", next_pc); end
    tick();
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL after_rets_empty got=%b exp=1", ras_empty); end
    idle();
  endtask

  task automatic test_overflow();
    logic [5:0] exp_ret [4];
    logic [5:0] exp_call5, exp_under;
`ifdef NPC_RAS_TRAP_EN
    exp_ret   = '{6'h05, 6'h04, 6'h03, 6'h02};
    exp_call5 = 6'h3F;
    exp_under = 6'h3F;
`else
    exp_ret   = '{6'h06, 6'h05, 6'h04, 6'h03};
    exp_call5 = 6'h10;
    exp_under = 6'h21;
`endif
    idle();
    call = 1; jump_target = 6'h10;
    for (int i = 1; i <= 4; i++) begin
      pc = 6'(i);
      tick();
    end
    checks++; if (ras_full !== 1'b1) begin errors++; $display("FAIL full_after4 got=%b exp=1", ras_full); end
    pc = 6'h05; #1;
    checks++; if (next_pc !== exp_call5) begin errors++; $display("FAIL call5 got=%h exp=%h", next_pc, exp_call5); end
    tick();
    checks++; if (ras_full !== 1'b1) begin errors++; $display("FAIL full_after5 got=%b exp=1", ras_full); end
`ifdef NPC_RAS_TRAP_EN
    checks++; if (ras_fault !== 1'b1) begin errors++; $display("FAIL overflow_fault got=%b exp=1", ras_fault); end
`else
    checks++; if (ras_fault !== 1'b0) begin errors++; $display("FAIL fault_tied got=%b exp=0", ras_fault); end
`endif
    idle();
    ret = 1; pc = 6'h10;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (next_pc !== exp_ret[i]) begin errors++; $display("FAIL ovf_ret%0d got=%h exp=%h", i, next_pc, exp_ret[i]); end
      tick();
    end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ovf_drain_empty got=%b exp=1", ras_empty); end
    pc = 6'h20; #1;
    checks++; if (next_pc !== exp_under) begin errors++; $display("FAIL underflow got=%h exp=%h", next_pc, exp_under); end
    tick();
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL underflow_empty got=%b exp=1", ras_empty); end
    idle();
  endtask

  task automatic test_stall();
    idle();
    pc = 6'h08; call = 1; jump_target = 6'h18;
    tick();
    stall = 1; ret = 1; pc = 6'h18; #1;
    checks++; if (next_pc !== 6'h18) begin errors++; $display("FAIL stall_hold got=%h exp=18", next_pc); end
    tick();
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL stall_no_pop got=%b exp=0", ras_empty); end
    stall = 0; pc = 6'h0A; jump_target = 6'h30; #1;
    checks++; if (next_pc !== 6'h09) begin errors++; $display("FAIL call_ret_pop got=%h exp=09", next_pc); end
    tick();
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL call_ret_no_push got=%b exp=1", ras_empty); end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp_under;
`ifdef NPC_RAS_TRAP_EN
    exp_under = 6'h3F;
`else
    exp_under = 6'h08;
`endif
    idle();
    call = 1; jump_target = 6'h28;
    for (int i = 0; i < 3; i++) begin
      pc = 6'(6'h01 + i);
      tick();
    end
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL pre_reset_empty got=%b exp=0", ras_empty); end
    idle();
    #2;
    reset_n = 0;
    #1;
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL midreset_empty got=%b exp=1", ras_empty); end
    checks++; if (next_pc !== 6'h00) begin errors++; $display("FAIL midreset_next_pc got=%h exp=00", next_pc); end
    checks++; if (ras_fault !== 1'b0) begin errors++; $display("FAIL midreset_fault got=%b exp=0", ras_fault); end
    tick();
    @(negedge clock);
    reset_n = 1;
    pc = 6'h07; ret = 1; #1;
    checks++; if (next_pc !== exp_under) begin errors++; $display("FAIL post_reset_ret got=%h exp=%h", next_pc, exp_under); end
    tick();
`ifdef NPC_RAS_TRAP_EN
    checks++; if (ras_fault !== 1'b1) begin errors++; $display("FAIL underflow_fault got=%b exp=1", ras_fault); end
`else
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL post_reset_empty got=%b exp=1", ras_empty); end
`endif
    idle();
  endtask

  initial begin
    test_reset();
    test_seq_branch();
    test_call_ret();
    test_overflow();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
